// File: rtl/cmp_sort_ctrl.sv
// Bubble-sort sequencer: loads N values, sorts them in place using one shared
// external combinational comparator (one compare per cycle), then streams them out.
module cmp_sort_ctrl #(
   parameter int N = 4,
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   input  logic         in_desc,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         out_last,
   output logic         busy,
   output logic [W-1:0] cmp_a,
   output logic [W-1:0] cmp_b,
   input  logic [2:0]   cmp_c,
   output logic         cmp_err
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);
   localparam logic [IW-1:0] LAST_PASS = IW'(N - 2);

   if (N < 2 || N > 8 || W != 4) begin : g_param_check
      $error("cmp_sort_ctrl: N must be in 2..8 and W must be 4");
   end

   typedef enum logic [1:0] {S_LOAD, S_SORT, S_OUT} state_e;

   state_e        state_q, state_d;
   logic [W-1:0]  data_q [N];
   logic [W-1:0]  data_d [N];
   logic [IW-1:0] wr_idx_q, wr_idx_d;
   logic [IW-1:0] rd_idx_q, rd_idx_d;
   logic [IW-1:0] i_q, i_d;
   logic [IW-1:0] pass_q, pass_d;
   logic          swapped_q, swapped_d;
   logic          desc_q, desc_d;
   logic          cmp_err_q, cmp_err_d;

   logic          cmp_onehot;
   logic          swap;
   logic          swapped_any;
   logic          end_of_pass;

   // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      data_d      = data_q;
      wr_idx_d    = wr_idx_q;
      rd_idx_d    = rd_idx_q;
      i_d         = i_q;
      pass_d      = pass_q;
      swapped_d   = swapped_q;
      desc_d      = desc_q;
      cmp_err_d   = cmp_err_q;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      out_data    = '0;
      out_last    = 1'b0;
      busy        = 1'b0;
      cmp_a       = '0;
      cmp_b       = '0;
      cmp_onehot  = (cmp_c == 3'b001) || (cmp_c == 3'b010) || (cmp_c == 3'b100);
      swap        = 1'b0;
      swapped_any = swapped_q;
      end_of_pass = 1'b0;

      case (state_q)
         S_LOAD: begin
            in_ready = 1'b1;
            if (in_valid) begin
               data_d[wr_idx_q] = in_data;
               if (wr_idx_q == '0) begin
                  desc_d    = in_desc;
                  cmp_err_d = 1'b0;
               end
               if (wr_idx_q == LAST_IDX) begin
                  state_d   = S_SORT;
                  wr_idx_d  = '0;
                  i_d       = '0;
                  pass_d    = '0;
                  swapped_d = 1'b0;
               end else begin
                  wr_idx_d = wr_idx_q + IW'(1);
               end
            end
         end

         S_SORT: begin
            busy  = 1'b1;
            cmp_a = data_q[i_q];
            cmp_b = data_q[i_q + IW'(1)];
            // A malformed comparator result is flagged and treated as "keep order".
            swap  = cmp_onehot & (desc_q ? cmp_c[0] : cmp_c[1]);
            if (!cmp_onehot) begin
               cmp_err_d = 1'b1;
            end
            if (swap) begin
               data_d[i_q]          = data_q[i_q + IW'(1)];
               data_d[i_q + IW'(1)] = data_q[i_q];
            end
            // The swap made in this cycle counts toward the pass, or a late swap could exit unsorted.
            swapped_any = swapped_q | swap;
            end_of_pass = (i_q == LAST_PASS - pass_q);
            if (end_of_pass) begin
               if (!swapped_any || pass_q == LAST_PASS) begin
                  state_d  = S_OUT;
                  rd_idx_d = '0;
               end else begin
                  pass_d    = pass_q + IW'(1);
                  i_d       = '0;
                  swapped_d = 1'b0;
               end
            end else begin
               i_d       = i_q + IW'(1);
               swapped_d = swapped_any;
            end
         end

         S_OUT: begin
            out_valid = 1'b1;
            out_data  = data_q[rd_idx_q];
            out_last  = (rd_idx_q == LAST_IDX);
            if (out_ready) begin
               if (rd_idx_q == LAST_IDX) begin
                  state_d  = S_LOAD;
                  rd_idx_d = '0;
                  wr_idx_d = '0;
               end else begin
                  rd_idx_d = rd_idx_q + IW'(1);
               end
            end
         end

         default: state_d = S_LOAD;
      endcase
   end

   assign cmp_err = cmp_err_q;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_LOAD;
         wr_idx_q  <= '0;
         rd_idx_q  <= '0;
         i_q       <= '0;
         pass_q    <= '0;
         swapped_q <= 1'b0;
         desc_q    <= 1'b0;
         cmp_err_q <= 1'b0;
         // NOTE: the value buffer is reset too, so an aborted batch leaves no stale data behind.
         for (int k = 0; k < N; k++) begin
            data_q[k] <= '0;
         end
      end else begin
         state_q   <= state_d;
         wr_idx_q  <= wr_idx_d;
         rd_idx_q  <= rd_idx_d;
         i_q       <= i_d;
         pass_q    <= pass_d;
         swapped_q <= swapped_d;
         desc_q    <= desc_d;
         cmp_err_q <= cmp_err_d;
         for (int k = 0; k < N; k++) begin
            data_q[k] <= data_d[k];
         end
      end
   end

endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// Self-checking bench for cmp_sort_ctrl: models the external comparator (with fault
// injection) and scoreboards the sorted output stream against hand-derived expectations.
module tb_cmp_sort_ctrl;

   localparam int N = 4;
   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         in_desc;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic         out_last;
   logic         busy;
   logic [W-1:0] cmp_a;
   logic [W-1:0] cmp_b;
   logic [2:0]   cmp_c;
   logic         cmp_err;

   int errors = 0;
   int checks = 0;
   int busy_cnt;
   int fault_at = 0;

   logic [4:0] exp_q [$];

   always #5 clk = ~clk;

   cmp_sort_ctrl #(.N(N), .W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_desc   (in_desc),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy),
      .cmp_a     (cmp_a),
      .cmp_b     (cmp_b),
      .cmp_c     (cmp_c),
      .cmp_err   (cmp_err)
   );

   // External comparator, with an optional malformed result on compare number fault_at.
   assign cmp_c = (fault_at != 0 && busy && busy_cnt == fault_at - 1) ? 3'b011 :
                  (cmp_a == cmp_b) ? 3'b100 :
                  (cmp_a >  cmp_b) ? 3'b010 : 3'b001;

   // Compare cycles in the current batch.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     busy_cnt <= 0;
      else if (in_valid && in_ready)  busy_cnt <= 0;
      else if (busy)                  busy_cnt <= busy_cnt + 1;
   end

   task automatic send_batch(input logic [3:0] d0, input logic [3:0] d1,
                             input logic [3:0] d2, input logic [3:0] d3, input logic desc);
      logic [3:0] v [4];
      v = '{d0, d1, d2, d3};
      for (int k = 0; k < 4; k++) begin
         int t;
         t = 0;
         in_valid = 1'b1;
         in_data  = v[k];
         in_desc  = (k == 0) ? desc : ~desc;
         while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
         end
         if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout beat=%0d in_ready=%b required 1", k, in_ready);
         end
         @(negedge clk);
         if (k == 0) begin
            checks++;
            if (cmp_err !== 1'b0) begin
               errors++;
               $display("FAIL cmp_err_clear_on_first_beat got=%b required 0", cmp_err);
            end
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic push_exp(input logic [3:0] e0, input logic [3:0] e1,
                           input logic [3:0] e2, input logic [3:0] e3);
      exp_q.push_back({1'b0, e0});
      exp_q.push_back({1'b0, e1});
      exp_q.push_back({1'b0, e2});
      exp_q.push_back({1'b1, e3});
   endtask

   task automatic wait_sorted(input int exp_cmp, input string name);
      int t;
      t = 0;
      while (!out_valid && t < 60) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL %s_out_valid_timeout got=%b required 1", name, out_valid);
      end
      checks++;
      if (busy_cnt !== exp_cmp) begin
         errors++;
         $display("FAIL %s_compare_cycles got=%0d required %0d", name, busy_cnt, exp_cmp);
      end
      checks++;
      if (busy !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s_out_state busy=%b in_ready=%b required 0/0", name, busy, in_ready);
      end
   endtask

   task automatic drain(input int stall, input bit rnd, input string name);
      int t;
      logic [4:0] e;
      t = 0;
      for (int s = 0; s < stall; s++) begin
         out_ready = 1'b0;
         in_valid  = 1'b1;
         in_data   = 4'hF;
         if (exp_q.size() > 0) begin
            checks++;
            if (out_data !== exp_q[0][3:0] || out_valid !== 1'b1 || in_ready !== 1'b0) begin
               errors++;
               $display("FAIL %s_stall cycle=%0d data=%0d valid=%b in_ready=%b required %0d/1/0",
                        name, s, out_data, out_valid, in_ready, exp_q[0][3:0]);
            end
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      while (exp_q.size() > 0 && t < 200) begin
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (out_valid && out_ready) begin
            e = exp_q.pop_front();
            checks++;
            if ({out_last, out_data} !== e) begin
               errors++;
               $display("FAIL %s_beat last/data got=%b/%0d required %b/%0d",
                        name, out_last, out_data, e[4], e[3:0]);
            end
            checks++;
            if (in_ready !== 1'b0) begin
               errors++;
               $display("FAIL %s_in_ready_during_out got=%b required 0", name, in_ready);
            end
         end
         @(negedge clk);
         t++;
      end
      out_ready = 1'b0;
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s_drain_timeout remaining=%0d required 0", name, exp_q.size());
         exp_q.delete();
      end
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s_after_last in_ready=%b out_valid=%b required 1/0", name, in_ready, out_valid);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 ||
          cmp_a !== 4'd0 || cmp_b !== 4'd0 || cmp_err !== 1'b0) begin
         errors++;
         $display("FAIL %s in_ready=%b out_valid=%b out_last=%b busy=%b cmp_a=%0d cmp_b=%0d cmp_err=%b required 1/0/0/0/0/0/0",
                  name, in_ready, out_valid, out_last, busy, cmp_a, cmp_b, cmp_err);
      end
   endtask

   task automatic test_reset();
      check_reset_outputs("reset_state");
   endtask

   task automatic test_ascending();
      send_batch(4'd9, 4'd7, 4'd3, 4'd1, 1'b0);
      push_exp(4'd1, 4'd3, 4'd7, 4'd9);
      wait_sorted(6, "asc_reverse");
      drain(0, 1'b0, "asc_reverse");
   endtask

   task automatic test_descending_early_exit();
      send_batch(4'd2, 4'd5, 4'd8, 4'd15, 1'b1);
      push_exp(4'd15, 4'd8, 4'd5, 4'd2);
      wait_sorted(6, "desc_full");
      drain(0, 1'b0, "desc_full");
      send_batch(4'd15, 4'd8, 4'd5, 4'd2, 1'b1);
      push_exp(4'd15, 4'd8, 4'd5, 4'd2);
      wait_sorted(3, "desc_presorted");
      drain(0, 1'b0, "desc_presorted");
   endtask

   task automatic test_equal();
      send_batch(4'd4, 4'd4, 4'd4, 4'd4, 1'b0);
      push_exp(4'd4, 4'd4, 4'd4, 4'd4);
      wait_sorted(3, "all_equal");
      checks++;
      if (cmp_err !== 1'b0) begin
         errors++;
         $display("FAIL all_equal_cmp_err got=%b required 0", cmp_err);
      end
      drain(0, 1'b0, "all_equal");
      send_batch(4'd6, 4'd0, 4'd6, 4'd0, 1'b0);
      push_exp(4'd0, 4'd0, 4'd6, 4'd6);
      wait_sorted(6, "dup_pairs");
      drain(0, 1'b0, "dup_pairs");
   endtask

   task automatic test_back_pressure();
      send_batch(4'd5, 4'd3, 4'd9, 4'd1, 1'b0);
      push_exp(4'd1, 4'd3, 4'd5, 4'd9);
      wait_sorted(6, "backpressure");
      drain(5, 1'b1, "backpressure");
   endtask

   task automatic test_cmp_fault();
      fault_at = 2;
      send_batch(4'd9, 4'd7, 4'd3, 4'd1, 1'b0);
      // Second compare (9 vs 3) is corrupted and skipped: 7,9,3,1 -> ... -> 1,7,9,3.
      push_exp(4'd1, 4'd7, 4'd9, 4'd3);
      wait_sorted(6, "cmp_fault");
      fault_at = 0;
      checks++;
      if (cmp_err !== 1'b1) begin
         errors++;
         $display("FAIL cmp_fault_flag_in_out got=%b required 1", cmp_err);
      end
      drain(0, 1'b0, "cmp_fault");
      checks++;
      if (cmp_err !== 1'b1) begin
         errors++;
         $display("FAIL cmp_fault_flag_sticky got=%b required 1", cmp_err);
      end
   endtask

   task automatic test_reset_mid_sort();
      int t;
      t = 0;
      send_batch(4'd9, 4'd7, 4'd3, 4'd1, 1'b0);
      while (busy_cnt < 2 && t < 50) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_in_sort busy=%b required 1", busy);
      end
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_reset_immediate");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("mid_reset_after_release");
      send_batch(4'd1, 4'd0, 4'd3, 4'd2, 1'b0);
      push_exp(4'd0, 4'd1, 4'd2, 4'd3);
      wait_sorted(5, "post_reset");
      drain(0, 1'b0, "post_reset");
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_desc   = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      test_reset();
      rst_n = 1'b1;
      @(negedge clk);
      test_ascending();
      test_descending_early_exit();
      test_equal();
      test_back_pressure();
      test_cmp_fault();
      test_reset_mid_sort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cmp_sort_ctrl.md
Name: cmp_sort_ctrl

Overview:
- Sequencer that shares one external 4-bit magnitude comparator across a bubble sort of N 4-bit values.
- Accepts N values over a valid/ready input stream and sorts them in place, one comparison per cycle, through the comparator's cmp_a/cmp_b/cmp_c interface.
- Streams the sorted values out over a valid/ready output stream.
- Sits between the operand source and result consumer in the Lab1 datapath; the comparator itself stays purely combinational.

Parameters:
- N, 4, number of values per sort batch; legal range 2..8.
- W, 4, data width; fixed at 4 to match the comparator. Any other value is illegal.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept an input beat.
- in_data  input  W  input value.
- in_desc  input  1  sort order, sampled on the first beat of a batch: 0 = ascending, 1 = descending.
- out_valid  output  1  output beat valid.
- out_ready  input  1  consumer accepts the output beat.
- out_data  output  W  sorted value.
- out_last  output  1  marks the final (Nth) output beat.
- busy  output  1  high in SORT state.
- cmp_a  output  W  comparator operand a.
- cmp_b  output  W  comparator operand b.
- cmp_c  input  3  comparator result: [2] = a==b, [1] = a>b, [0] = a<b.
- cmp_err  output  1  sticky flag: cmp_c was not one-hot during a compare.

Behaviour:
- Reset (async assert, sync-safe release):
  - state = LOAD; buffer, counters and swap flag = 0.
  - in_ready = 1, out_valid = 0, out_last = 0, busy = 0.
  - cmp_a = cmp_b = 0, cmp_err = 0.
- Reset mid-batch discards the batch with no partial output.
- States:
  - LOAD: in_ready = 1. Each in_valid&in_ready beat writes buf[wr_idx] and increments wr_idx. in_desc is latched when wr_idx == 0. cmp_err clears on that first beat. The beat with wr_idx == N-1 moves to SORT with i = 0, pass = 0, swapped = 0.
  - SORT: in_ready = 0, busy = 1. Combinationally, cmp_a = buf[i] and cmp_b = buf[i+1]; both are 0 outside SORT.
    - Swap condition: ascending uses cmp_c[1]; descending uses cmp_c[0]. Equal values never swap, so the sort is stable.
    - On a swap, the next edge exchanges buf[i] and buf[i+1] and sets swapped.
    - If cmp_c is not exactly one-hot, set cmp_err and do not swap.
    - End of pass is i == N-2-pass. If swapped == 0 or pass == N-2, go to OUT; otherwise pass++, i = 0, swapped = 0. If not end of pass, i++.
  - OUT: out_valid = 1, out_data = buf[rd_idx], out_last = (rd_idx == N-1). On out_valid&out_ready, rd_idx++. The last handshake returns to LOAD with wr_idx = rd_idx = 0.
- Handshake rules:
  - out_data and out_last hold stable while out_valid=1 and out_ready=0.
  - No combinational path from out_ready to in_ready.
- Latency:
  - Sort takes 1 cycle per compare: worst case N(N-1)/2 cycles (6 for N=4); best case N-1 cycles (already sorted).
  - First out_valid is asserted in the cycle after the final compare.
- Throughput: no overlap between batches. in_ready = 0 from the cycle after the Nth input beat until the cycle after the Nth output handshake.
- Boundaries:
  - in_valid is ignored outside LOAD.
  - in_desc is ignored on beats after the first.
  - Identical values complete after one pass with no swaps.
  - wr_idx and rd_idx never wrap past N-1.

Test Plan:
- Ascending, reverse input: in 9,7,3,1, desc=0 -> out 1,3,7,9; busy for 6 cycles; out_last only on 9.
- Descending, early exit: in 2,5,8,15, desc=1 -> out 15,8,5,2 after 6 compares. Then a second batch 15,8,5,2 desc=1 -> busy for exactly 3 cycles, unchanged order.
- Stability/equality: in 4,4,4,4 -> 3 compare cycles, out 4,4,4,4, cmp_err=0. Also in 6,0,6,0 asc -> 0,0,6,6.
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid rises -> out_data stays at the first sorted value, in_ready=0. Release, then random out_ready -> correct order, in_ready=1 only after the 4th handshake.
- Comparator fault: force cmp_c=3'b011 on the 2nd compare of batch 9,7,3,1 -> cmp_err=1 and no swap at that step; flag persists through OUT and clears on the next batch's first input beat.
- Reset mid-operation: assert rst_n=0 during SORT after 2 compares -> outputs take reset values immediately; after release, in_ready=1 and a new batch 1,0,3,2 asc -> 0,1,2,3.
